// File: rtl/cache_set_array_pkg.sv
// cache_set_array_pkg: shared encodings for the set-associative cache array.
// Holds the MESI state, cache op and array FSM enums, plus the snoop-read
// downgrade helper. The line struct depends on the array widths, so it lives
// in the top module next to its parameters.
package cache_set_array_pkg;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_t;

    typedef enum logic [2:0] {
        OP_READ      = 3'd0,
        OP_WRITE     = 3'd1,
        OP_FILL      = 3'd2,
        OP_SNOOP_RD  = 3'd3,
        OP_SNOOP_INV = 3'd4
    } cache_op_t;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // A snoop read leaves a shared copy behind: owned/exclusive lines drop to S.
    function automatic mesi_t snoop_rd_mesi(input mesi_t m);
        return (m == MESI_M || m == MESI_E) ? MESI_S : m;
    endfunction

endpackage

// File: rtl/cache_lru_ctrl.sv
// cache_lru_ctrl: victim selection and true-LRU update for one set.
// Ports: i_lru      flat per-way LRU ranks (way i at [i*WAY_W +: WAY_W])
//        i_valid    per-way "MESI != I" mask
//        i_touch_way way being made most-recently used
//        o_victim   lowest invalid way, else the way ranked WAYS-1
//        o_lru_next LRU ranks after touching i_touch_way
module cache_lru_ctrl #(
    parameter int WAYS = 8,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS*WAY_W-1:0] i_lru,
    input  logic [WAYS-1:0]       i_valid,
    input  logic [WAY_W-1:0]      i_touch_way,
    output logic [WAY_W-1:0]      o_victim,
    output logic [WAYS*WAY_W-1:0] o_lru_next
);

    logic [WAY_W-1:0] w_old;

    // Descending scan so the lowest-index invalid way wins over the LRU way.
    always_comb begin
        o_victim = '0;
        for (int i = 0; i < WAYS; i++)
            if (i_lru[i*WAY_W +: WAY_W] == WAY_W'(WAYS-1)) o_victim = WAY_W'(i);
        for (int i = WAYS-1; i >= 0; i--)
            if (!i_valid[i]) o_victim = WAY_W'(i);
    end

    // Kept separate from victim selection: the touched way may be the victim.
    always_comb begin
        w_old = i_lru[i_touch_way*WAY_W +: WAY_W];
        o_lru_next = i_lru;
        for (int i = 0; i < WAYS; i++)
            o_lru_next[i*WAY_W +: WAY_W] = (WAY_W'(i) == i_touch_way) ? '0 :
                (i_lru[i*WAY_W +: WAY_W] < w_old) ? i_lru[i*WAY_W +: WAY_W] + 1'b1 :
                i_lru[i*WAY_W +: WAY_W];
    end

endmodule

// File: rtl/cache_set_array.sv
// cache_set_array: set-associative tag/data/MESI array with true-LRU replacement.
// Ports: clk/rst (sync, active-high); req_* valid/ready request (op, set, tag,
//        data, fill mesi); resp_* registered response one cycle after accept
//        (hit, way, old mesi/data, eviction of an M line and its tag);
//        init_done after the post-reset sweep; stat_* counters.
// Macro CACHE_STATS_EN enables saturating hit/miss/evict counters; without it
// the stat_* ports are tied to 0.
module cache_set_array
    import cache_set_array_pkg::*;
#(
    parameter int SETS   = 16384,
    parameter int WAYS   = 8,
    parameter int TAG_W  = 12,
    parameter int DATA_W = 32,
    localparam int SET_W = $clog2(SETS),
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [SET_W-1:0]  req_set,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic [DATA_W-1:0] req_data,
    input  logic [1:0]        req_mesi,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [WAY_W-1:0]  resp_way,
    output logic [1:0]        resp_mesi,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_evict,
    output logic [TAG_W-1:0]  resp_evict_tag,
    output logic              init_done,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses,
    output logic [31:0]       stat_evicts
);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [WAY_W-1:0]  lru;
        mesi_t             mesi;
        logic [DATA_W-1:0] data;
    } cache_line_t;

    cache_line_t          r_mem [SETS][WAYS];
    state_t               r_state, w_state_next;
    logic [SET_W-1:0]     r_init_cnt;
    cache_line_t          w_set [WAYS];
    cache_line_t          w_new_set [WAYS];
    logic [WAYS-1:0]      w_hit_vec, w_valid_vec;
    logic [WAY_W-1:0]     w_hit_way, w_victim, w_tgt_way;
    logic [WAYS*WAY_W-1:0] w_lru_flat, w_lru_next;
    logic                 w_hit, w_accept, w_is_rw, w_touch, w_evict;

    assign req_ready = r_state == ST_READY;
    assign init_done = r_state == ST_READY;
    assign w_accept  = req_valid && req_ready;
    assign w_hit     = |w_hit_vec;
    assign w_tgt_way = w_hit ? w_hit_way : w_victim;
    assign w_is_rw   = req_op == OP_READ || req_op == OP_WRITE;
    assign w_touch   = (w_is_rw && w_hit) || req_op == OP_FILL;
    assign w_evict   = req_op == OP_FILL && !w_hit && w_set[w_tgt_way].mesi == MESI_M;

    always_comb w_state_next = (r_state == ST_INIT && r_init_cnt == SET_W'(SETS-1)) ? ST_READY : r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + 1'b1;
        end
    end

    always_comb begin
        w_hit_vec   = '0;
        w_valid_vec = '0;
        w_hit_way   = '0;
        w_lru_flat  = '0;
        for (int i = 0; i < WAYS; i++) begin
            w_set[i]       = r_mem[req_set][i];
            w_valid_vec[i] = w_set[i].mesi != MESI_I;
            w_hit_vec[i]   = w_valid_vec[i] && w_set[i].tag == req_tag;
            if (w_hit_vec[i]) w_hit_way = WAY_W'(i);
            w_lru_flat[i*WAY_W +: WAY_W] = w_set[i].lru;
        end
    end

    cache_lru_ctrl #(.WAYS(WAYS)) u_lru (
        .i_lru      (w_lru_flat),
        .i_valid    (w_valid_vec),
        .i_touch_way(w_tgt_way),
        .o_victim   (w_victim),
        .o_lru_next (w_lru_next)
    );

    // Whole-set image after the op; written back on every accept (no-op for
    // misses and reserved ops since it equals the current contents).
    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            w_new_set[i] = w_set[i];
            if (w_touch) w_new_set[i].lru = w_lru_next[i*WAY_W +: WAY_W];
        end
        if (req_op == OP_WRITE && w_hit) begin
            w_new_set[w_tgt_way].data = req_data;
            w_new_set[w_tgt_way].mesi = MESI_M;
        end
        if (req_op == OP_FILL) begin
            w_new_set[w_tgt_way].tag  = req_tag;
            w_new_set[w_tgt_way].data = req_data;
            w_new_set[w_tgt_way].mesi = mesi_t'(req_mesi);
        end
        if (req_op == OP_SNOOP_RD && w_hit) w_new_set[w_tgt_way].mesi = snoop_rd_mesi(w_set[w_tgt_way].mesi);
        if (req_op == OP_SNOOP_INV && w_hit) w_new_set[w_tgt_way].mesi = MESI_I;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_INIT) begin
                for (int i = 0; i < WAYS; i++)
                    r_mem[r_init_cnt][i] <= '{tag: '0, lru: WAY_W'(i), mesi: MESI_I, data: '0};
            end else if (w_accept) begin
                for (int i = 0; i < WAYS; i++) r_mem[req_set][i] <= w_new_set[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid     <= 1'b0;
            resp_hit       <= 1'b0;
            resp_way       <= '0;
            resp_mesi      <= '0;
            resp_data      <= '0;
            resp_evict     <= 1'b0;
            resp_evict_tag <= '0;
        end else begin
            resp_valid <= w_accept;
            if (w_accept) begin
                resp_hit       <= w_hit && req_op <= OP_SNOOP_INV;
                resp_way       <= w_tgt_way;
                resp_mesi      <= w_set[w_tgt_way].mesi;
                resp_data      <= w_set[w_tgt_way].data;
                resp_evict     <= w_evict;
                resp_evict_tag <= w_set[w_tgt_way].tag;
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] r_hits, r_misses, r_evicts;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hits   <= '0;
            r_misses <= '0;
            r_evicts <= '0;
        end else if (w_accept) begin
            if (w_is_rw && w_hit && ~&r_hits) r_hits <= r_hits + 1'b1;
            if (w_is_rw && !w_hit && ~&r_misses) r_misses <= r_misses + 1'b1;
            if (w_evict && ~&r_evicts) r_evicts <= r_evicts + 1'b1;
        end
    end

    assign stat_hits   = r_hits;
    assign stat_misses = r_misses;
    assign stat_evicts = r_evicts;
`else
    assign stat_hits   = '0;
    assign stat_misses = '0;
    assign stat_evicts = '0;
`endif

endmodule

// File: tb/tb_cache_set_array.sv
// tb_cache_set_array: directed self-checking bench for cache_set_array (SETS=16, WAYS=8).
module tb_cache_set_array;
    import cache_set_array_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [3:0]  req_set = '0;
    logic [11:0] req_tag = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_mesi = '0;
    logic        resp_valid, resp_hit, resp_evict, init_done;
    logic [2:0]  resp_way;
    logic [1:0]  resp_mesi;
    logic [31:0] resp_data;
    logic [11:0] resp_evict_tag;
    logic [31:0] stat_hits, stat_misses, stat_evicts;

    int checks = 0;
    int failures = 0;

    cache_set_array #(.SETS(16), .WAYS(8), .TAG_W(12), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_set(req_set), .req_tag(req_tag), .req_data(req_data),
        .req_mesi(req_mesi), .resp_valid(resp_valid), .resp_hit(resp_hit),
        .resp_way(resp_way), .resp_mesi(resp_mesi), .resp_data(resp_data),
        .resp_evict(resp_evict), .resp_evict_tag(resp_evict_tag), .init_done(init_done),
        .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_evicts(stat_evicts)
    );

    always #5 clk = ~clk;

    // Drive one request for one cycle; returns at the negedge after the accept
    // edge, where the registered response is visible.
    task automatic do_req(input logic [2:0] op, input logic [3:0] set, input logic [11:0] tag,
                          input logic [31:0] data, input logic [1:0] mesi);
        @(negedge clk);
        req_op = op; req_set = set; req_tag = tag; req_data = data; req_mesi = mesi;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        logic seen;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", req_ready); end
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done got=%0b exp=0", init_done); end
        checks++; if (resp_valid !== 1'b0 || resp_hit !== 1'b0 || resp_evict !== 1'b0 || resp_data !== 32'h0)
            begin failures++; $display("FAIL reset_resp got=%0b/%0b/%0b/%h exp=0/0/0/0", resp_valid, resp_hit, resp_evict, resp_data); end
        rst = 1'b0;
        req_op = OP_FILL; req_set = 4'd3; req_tag = 12'h5; req_data = 32'h1; req_mesi = MESI_M;
        req_valid = 1'b1;
        n = 0; seen = 1'b0;
        while (!req_ready && n < 100) begin
            n++;
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        req_valid = 1'b0;
        checks++; if (n !== 16) begin failures++; $display("FAIL init_cycles got=%0d exp=16", n); end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL init_ignores_req got=%0b exp=0", seen); end
        checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL init_done got=%0b exp=1", init_done); end
        do_req(OP_READ, 4'd3, 12'h5, 32'h0, MESI_I);
        checks++; if (resp_valid !== 1'b1 || resp_hit !== 1'b0 || resp_way !== 3'd0)
            begin failures++; $display("FAIL first_read got=v%0b h%0b w%0d exp=v1 h0 w0", resp_valid, resp_hit, resp_way); end
    endtask

    task automatic test_fill_read_write;
        do_req(OP_FILL, 4'd3, 12'h5, 32'hDEADBEEF, MESI_E);
        checks++; if (resp_hit !== 1'b0 || resp_way !== 3'd0 || resp_evict !== 1'b0)
            begin failures++; $display("FAIL fill_resp got=h%0b w%0d e%0b exp=h0 w0 e0", resp_hit, resp_way, resp_evict); end
        do_req(OP_READ, 4'd3, 12'h5, 32'h0, MESI_I);
        checks++; if (resp_hit !== 1'b1 || resp_data !== 32'hDEADBEEF || resp_mesi !== MESI_E)
            begin failures++; $display("FAIL read_after_fill got=h%0b d%h m%0d exp=h1 dDEADBEEF m2", resp_hit, resp_data, resp_mesi); end
        do_req(OP_WRITE, 4'd3, 12'h5, 32'h12345678, MESI_I);
        checks++; if (resp_hit !== 1'b1 || resp_mesi !== MESI_E)
            begin failures++; $display("FAIL write_resp got=h%0b m%0d exp=h1 m2", resp_hit, resp_mesi); end
        do_req(OP_READ, 4'd3, 12'h5, 32'h0, MESI_I);
        checks++; if (resp_mesi !== MESI_M || resp_data !== 32'h12345678)
            begin failures++; $display("FAIL read_after_write got=m%0d d%h exp=m3 d12345678", resp_mesi, resp_data); end
    endtask

    task automatic test_lru;
        for (int k = 0; k < 8; k++) do_req(OP_FILL, 4'd1, 12'(12'h100 + k), 32'(k), MESI_E);
        checks++; if (resp_way !== 3'd7) begin failures++; $display("FAIL lru_8th_fill_way got=%0d exp=7", resp_way); end
        do_req(OP_READ, 4'd1, 12'h100, 32'h0, MESI_I);
        checks++; if (resp_hit !== 1'b1 || resp_way !== 3'd0)
            begin failures++; $display("FAIL lru_read_way0 got=h%0b w%0d exp=h1 w0", resp_hit, resp_way); end
        do_req(OP_FILL, 4'd1, 12'h108, 32'h8, MESI_E);
        checks++; if (resp_hit !== 1'b0 || resp_way !== 3'd1 || resp_evict !== 1'b0 || resp_evict_tag !== 12'h101 || resp_mesi !== MESI_E)
            begin failures++; $display("FAIL lru_victim got=h%0b w%0d e%0b t%h m%0d exp=h0 w1 e0 t101 m2", resp_hit, resp_way, resp_evict, resp_evict_tag, resp_mesi); end
        do_req(OP_READ, 4'd1, 12'h101, 32'h0, MESI_I);
        checks++; if (resp_hit !== 1'b0) begin failures++; $display("FAIL lru_evicted_gone got=%0b exp=0", resp_hit); end
    endtask

    task automatic test_evict;
        do_req(OP_FILL, 4'd2, 12'h200, 32'hAAAA0000, MESI_E);
        do_req(OP_WRITE, 4'd2, 12'h200, 32'hCAFEF00D, MESI_I);
        for (int k = 1; k < 8; k++) do_req(OP_FILL, 4'd2, 12'(12'h200 + k), 32'(k), MESI_E);
        do_req(OP_FILL, 4'd2, 12'h208, 32'h8, MESI_E);
        checks++; if (resp_way !== 3'd0 || resp_evict !== 1'b1 || resp_evict_tag !== 12'h200 || resp_data !== 32'hCAFEF00D || resp_mesi !== MESI_M)
            begin failures++; $display("FAIL evict_m got=w%0d e%0b t%h d%h m%0d exp=w0 e1 t200 dCAFEF00D m3", resp_way, resp_evict, resp_evict_tag, resp_data, resp_mesi); end
    endtask

    task automatic test_snoop;
        do_req(OP_SNOOP_RD, 4'd3, 12'h5, 32'h0, MESI_I);
        checks++; if (resp_hit !== 1'b1 || resp_mesi !== MESI_M || resp_data !== 32'h12345678)
            begin failures++; $display("FAIL snoop_rd got=h%0b m%0d d%h exp=h1 m3 d12345678", resp_hit, resp_mesi, resp_data); end
        do_req(OP_READ, 4'd3, 12'h5, 32'h0, MESI_I);
        checks++; if (resp_hit !== 1'b1 || resp_mesi !== MESI_S)
            begin failures++; $display("FAIL read_after_snoop_rd got=h%0b m%0d exp=h1 m1", resp_hit, resp_mesi); end
        do_req(OP_SNOOP_INV, 4'd3, 12'h5, 32'h0, MESI_I);
        checks++; if (resp_hit !== 1'b1 || resp_mesi !== MESI_S)
            begin failures++; $display("FAIL snoop_inv got=h%0b m%0d exp=h1 m1", resp_hit, resp_mesi); end
        do_req(OP_READ, 4'd3, 12'h5, 32'h0, MESI_I);
        checks++; if (resp_hit !== 1'b0) begin failures++; $display("FAIL read_after_snoop_inv got=%0b exp=0", resp_hit); end
    endtask

    task automatic test_reserved;
        do_req(3'd5, 4'd1, 12'h100, 32'h0, MESI_I);
        checks++; if (resp_valid !== 1'b1 || resp_hit !== 1'b0)
            begin failures++; $display("FAIL reserved_op got=v%0b h%0b exp=v1 h0", resp_valid, resp_hit); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        req_op = OP_FILL; req_set = 4'd5; req_tag = 12'h77; req_data = 32'hA5A5; req_mesi = MESI_S;
        req_valid = 1'b1;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_hit !== 1'b0 || resp_way !== 3'd0)
            begin failures++; $display("FAIL b2b_fill got=v%0b h%0b w%0d exp=v1 h0 w0", resp_valid, resp_hit, resp_way); end
        req_op = OP_READ;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b1 || resp_hit !== 1'b1 || resp_mesi !== MESI_S || resp_data !== 32'hA5A5)
            begin failures++; $display("FAIL b2b_read got=v%0b h%0b m%0d d%h exp=v1 h1 m1 dA5A5", resp_valid, resp_hit, resp_mesi, resp_data); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || resp_data !== 32'hA5A5)
            begin failures++; $display("FAIL resp_hold got=v%0b d%h exp=v0 dA5A5", resp_valid, resp_data); end
    endtask

    task automatic test_midstream_reset;
        int n;
        @(negedge clk);
        req_op = OP_READ; req_set = 4'd1; req_tag = 12'h100; req_valid = 1'b1;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_resp got=%0b exp=1", resp_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0 || init_done !== 1'b0)
            begin failures++; $display("FAIL mid_reset got=v%0b r%0b d%0b exp=0/0/0", resp_valid, req_ready, init_done); end
        checks++; if (stat_hits !== 32'h0 || stat_misses !== 32'h0 || stat_evicts !== 32'h0)
            begin failures++; $display("FAIL stats_cleared got=%0d/%0d/%0d exp=0/0/0", stat_hits, stat_misses, stat_evicts); end
        n = 0;
        while (!req_ready && n < 100) begin n++; @(negedge clk); end
        checks++; if (n !== 16) begin failures++; $display("FAIL reinit_cycles got=%0d exp=16", n); end
        do_req(OP_READ, 4'd1, 12'h100, 32'h0, MESI_I);
        checks++; if (resp_hit !== 1'b0) begin failures++; $display("FAIL reinit_cleared got=%0b exp=0", resp_hit); end
    endtask

    initial begin
        test_reset;
        test_fill_read_write;
        test_lru;
        test_evict;
        test_snoop;
        test_reserved;
        test_back_to_back;
        test_midstream_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_set_array.md
Name: cache_set_array

Overview:
- Parametrised set-associative tag/data/state array with MESI state per line and true-LRU replacement; successor to the L1 cache storage block.
- Adds a valid/ready request interface, hit detection, victim selection with eviction reporting, snoop handling and a multi-cycle init sweep after reset.
- Sits between the cache controller FSM (issues ops) and the bus/snoop logic (consumes evictions and snoop results).

Parameters:
- SETS, 16384: number of sets; power of two.
- WAYS, 8: associativity; power of two, >= 2.
- TAG_W, 12: tag width.
- DATA_W, 32: line payload width.
- Derived locals: SET_W = $clog2(SETS), WAY_W = $clog2(WAYS).

Ports:
- clk  in  1  clock; one clock domain only.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request strobe.
- req_ready  out  1  array can accept a request.
- req_op  in  3  cache_op_t: OP_READ=0, OP_WRITE=1, OP_FILL=2, OP_SNOOP_RD=3, OP_SNOOP_INV=4; 5-7 reserved.
- req_set  in  SET_W  set index.
- req_tag  in  TAG_W  tag.
- req_data  in  DATA_W  write/fill data.
- req_mesi  in  2  mesi_t state for FILL.
- resp_valid  out  1  one-cycle response pulse.
- resp_hit  out  1  tag matched a non-I way.
- resp_way  out  WAY_W  hit way, or victim way on miss/fill.
- resp_mesi  out  2  state before the op.
- resp_data  out  DATA_W  line data before the op (hit or victim).
- resp_evict  out  1  FILL displaced a line in state M.
- resp_evict_tag  out  TAG_W  tag of displaced line.
- init_done  out  1  init sweep complete.
- stat_hits, stat_misses, stat_evicts  out  32 each  counters (see Optional Feature).

Behaviour:
- Reset (rst=1 at posedge): FSM -> INIT, sweep counter = 0. req_ready, resp_valid, init_done and all resp_* outputs = 0.
- INIT:
  - Each cycle clears set[counter]: every way gets MESI=I, tag=0, data=0, LRU=way index.
  - After SETS cycles -> READY; init_done=1, req_ready=1.
  - rst during INIT restarts the sweep at 0. req_valid in INIT is ignored with no response.
- READY: req_ready=1 every cycle. Accept = req_valid & req_ready.
- Latency: lookup and array update happen at the accept edge. Response is registered; resp_valid pulses exactly 1 cycle after accept.
- Back-to-back accepts to the same set see the previous update. Throughput is 1 request per cycle.
- Hit: some way has MESI != I and a matching tag. At most one way may match (FILL guarantees this).
- Victim selection: lowest-index way in state I; otherwise the way with LRU == WAYS-1.
- LRU touch of way w with old value v: ways with LRU < v increment, w gets 0. Values stay a permutation of 0..WAYS-1.
- OP_READ:
  - Hit: touch LRU; return data/mesi.
  - Miss: no state change; resp_way = victim.
- OP_WRITE:
  - Hit: data <= req_data; MESI -> M from any non-I state; touch LRU.
  - Miss: no change.
- OP_FILL:
  - If the tag already hits: overwrite that way, resp_evict=0.
  - Otherwise install into the victim. resp_data/resp_evict_tag report the old line; resp_evict=1 iff the old MESI was M.
  - New line gets req_tag, req_data, req_mesi; touch LRU.
  - req_mesi=I is legal (line stays invalid; LRU is still touched).
- OP_SNOOP_RD: on hit, M or E -> S; S unchanged; LRU unchanged. Response carries the old mesi and data so the caller can write back.
- OP_SNOOP_INV: on hit, -> I; LRU unchanged. Response carries the old mesi and data.
- Reserved ops: respond with resp_hit=0; no state change.
- resp_* outputs hold their values between pulses; only resp_valid qualifies them.

Optional Feature:
- Macro CACHE_STATS_EN.
- Defined:
  - stat_hits counts READ/WRITE hits.
  - stat_misses counts READ/WRITE misses.
  - stat_evicts counts FILLs with resp_evict=1.
  - Counters saturate at 32'hFFFF_FFFF and clear on rst.
- Undefined: the three ports are driven constant 0 and no counter flops exist.

Decomposition:
- my_struct_package holds:
  - mesi_t (I, S, E, M);
  - cache_op_t;
  - a parametrised line struct {tag, LRU, MESI, data} matching the existing cache_line_t;
  - op encodings.
- One sub-module: cache_lru_ctrl (combinational victim select plus next-LRU vector for one set).

Test Plan:
- rst for 1 cycle with SETS=16 -> req_ready=0 for exactly 16 cycles, then init_done=1; READ set 3 tag 0x5 -> resp_hit=0, resp_way=0.
- FILL set 3 tag 0x5 data 0xDEADBEEF mesi E, then READ -> resp_hit=1, resp_data=0xDEADBEEF, resp_mesi=E; WRITE then READ -> resp_mesi=M.
- FILL 8 distinct tags into set 1 (WAYS=8), READ tag of way 0, FILL 9th tag -> victim is way 1 (LRU=7), resp_evict=0 since it was E.
- Mark a line M via WRITE, then force its eviction by FILL -> resp_evict=1, resp_evict_tag is the old tag, resp_data is the old data.
- SNOOP_RD on an M line -> resp_mesi=M, next READ gives S; SNOOP_INV -> next READ misses.
- rst asserted mid-stream with a response pending -> resp_valid=0 next cycle; sweep restarts; with CACHE_STATS_EN the counters read 0.
